// File: rtl/median_rank_filter.sv
// Rank-order filter: loads a frame of N serial samples into a shift register, then
// runs partial bubble-sort passes (one compare-exchange per clock) until the requested
// rank has settled at the top, and emits that sample with a one-cycle strobe.
module median_rank_filter #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 9,
  parameter int unsigned RW = $clog2(N + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [W-1:0]  DI,
  input  logic          DSI,
  input  logic [RW-1:0] RANK,
  output logic          RDY,
  output logic [W-1:0]  DO,
  output logic          DSO,
  output logic          DROP
);

  localparam int unsigned CW      = $clog2(N);
  localparam int unsigned DefRank = (N + 1) / 2;

  typedef enum logic [1:0] {StLoad, StSort, StOut} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  p_q, p_d;
  logic [CW-1:0]  j_q, j_d;
  logic [RW-1:0]  rank_q, rank_d;
  logic [W-1:0]   r_q [N];
  logic [W-1:0]   r_d [N];
  logic [W-1:0]   do_q, do_d;
  logic           dso_q, dso_d;
  logic           drop_q;

  logic [RW-1:0]  rank_fix;
  logic [CW-1:0]  p_last;
  logic [CW-1:0]  j_last;
  logic [CW-1:0]  jn;
  logic [CW-1:0]  out_idx;

  assign RDY  = (state_q == StLoad);
  assign DO   = do_q;
  assign DSO  = dso_q;
  assign DROP = drop_q;

  // Rank decode, last pass/step indices and output tap for the current frame
  always_comb begin
    rank_fix = RANK;
    if (RANK == '0 || 32'(RANK) > N) rank_fix = RW'(DefRank);
    // r passes leave the r largest sorted at the top; N-1 passes already sort everything
    if (32'(rank_q) >= N - 1) p_last = CW'(N - 2);
    else                      p_last = CW'(32'(rank_q) - 1);
    j_last  = CW'(N - 2) - p_q;
    jn      = j_q + CW'(1);
    out_idx = CW'(N - 32'(rank_q));
  end

  // Next-state, shift/swap datapath and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    j_d     = j_q;
    rank_d  = rank_q;
    r_d     = r_q;
    do_d    = do_q;
    dso_d   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (DSI) begin
          r_d[0] = DI;
          for (int k = 1; k < N; k++) r_d[k] = r_q[k-1];
          if (cnt_q == '0) rank_d = rank_fix;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            p_d     = '0;
            j_d     = '0;
            state_d = StSort;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StSort: begin
        // Strict compare keeps equal values in place
        if (r_q[j_q] > r_q[jn]) begin
          r_d[j_q] = r_q[jn];
          r_d[jn]  = r_q[j_q];
        end
        if (j_q == j_last) begin
          j_d = '0;
          if (p_q == p_last) state_d = StOut;
          else               p_d = p_q + CW'(1);
        end else begin
          j_d = jn;
        end
      end
      StOut: begin
        do_d    = r_q[out_idx];
        dso_d   = 1'b1;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= StLoad;
    else       state_q <= state_d;
  end

  // Datapath, counters and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      p_q    <= '0;
      j_q    <= '0;
      rank_q <= RW'(DefRank);
      for (int k = 0; k < N; k++) r_q[k] <= '0;
      do_q   <= '0;
      dso_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      j_q    <= j_d;
      rank_q <= rank_d;
      r_q    <= r_d;
      do_q   <= do_d;
      dso_q  <= dso_d;
      drop_q <= DSI & ~RDY;
    end
  end

endmodule

// File: tb/tb_median_rank_filter.sv
// Directed bench for median_rank_filter: N=9/W=8 main instance plus W=12 instances
// with N=3 and N=25 checked against a sorting reference.
module tb_median_rank_filter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;

  logic [7:0]  di9 = '0;
  logic        dsi9 = 1'b0;
  logic [3:0]  rank9 = '0;
  logic        rdy9, dso9, drop9;
  logic [7:0]  do9;

  logic [11:0] di12 = '0;
  logic [4:0]  rank_s = '0;
  logic        dsi3 = 1'b0, dsi25 = 1'b0;
  logic        rdy3, dso3, drop3, rdy25, dso25, drop25;
  logic [11:0] do3, do25;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  median_rank_filter #(.W(8), .N(9)) u_dut9 (
    .CLK(CLK), .nRST(nRST), .DI(di9), .DSI(dsi9), .RANK(rank9),
    .RDY(rdy9), .DO(do9), .DSO(dso9), .DROP(drop9)
  );

  median_rank_filter #(.W(12), .N(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .DI(di12), .DSI(dsi3), .RANK(rank_s[1:0]),
    .RDY(rdy3), .DO(do3), .DSO(dso3), .DROP(drop3)
  );

  median_rank_filter #(.W(12), .N(25)) u_dut25 (
    .CLK(CLK), .nRST(nRST), .DI(di12), .DSI(dsi25), .RANK(rank_s),
    .RDY(rdy25), .DO(do25), .DSO(dso25), .DROP(drop25)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sort_cycles(input int n, input int r);
    int p_cnt = (r < n - 1) ? r : n - 1;
    int s = 0;
    for (int p = 0; p < p_cnt; p++) s += n - 1 - p;
    return s;
  endfunction

  function automatic logic cur_dso(input int sel);
    return (sel == 9) ? dso9 : (sel == 3) ? dso3 : dso25;
  endfunction

  function automatic logic cur_rdy(input int sel);
    return (sel == 9) ? rdy9 : (sel == 3) ? rdy3 : rdy25;
  endfunction

  function automatic logic [31:0] cur_do(input int sel);
    return (sel == 9) ? 32'(do9) : (sel == 3) ? 32'(do3) : 32'(do25);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges from the last accept until DSO, then checks latency, value, RDY and pulse width
  task automatic await_dso(input int sel, input int exp_lat, input logic [31:0] exp_do,
                           input string tag);
    int  e;
    logic rdy_ok = 1'b1;
    for (e = 1; e <= 500; e++) begin
      tick();
      if (cur_dso(sel)) break;
      if (cur_rdy(sel)) rdy_ok = 1'b0;
    end
    if (e > 500) begin
      check({tag, "_timeout"}, 32'(e), 32'(exp_lat));
    end else begin
      check({tag, "_lat"}, 32'(e), 32'(exp_lat));
      check({tag, "_do"}, cur_do(sel), exp_do);
      check({tag, "_rdy_busy"}, 32'(rdy_ok), 32'd1);
      check({tag, "_rdy_at_dso"}, 32'(cur_rdy(sel)), 32'd1);
      tick();
      check({tag, "_dso_pulse"}, 32'(cur_dso(sel)), 32'd0);
      check({tag, "_do_held"}, cur_do(sel), exp_do);
    end
  endtask

  // Feeds a 9-sample frame; RANK only valid with the first sample, garbage afterwards
  task automatic send9(input logic [7:0] d [9], input int rank, input int maxgap);
    for (int i = 0; i < 9; i++) begin
      int g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int k = 0; k < g; k++) begin
        dsi9 = 1'b0;
        di9  = 8'hEE;
        tick();
      end
      di9   = d[i];
      dsi9  = 1'b1;
      rank9 = (i == 0) ? 4'(rank) : 4'd1;
      tick();
    end
    dsi9 = 1'b0;
  endtask

  task automatic frame_small(input int n, input int r, input int maxval);
    int d [25];
    int s [25];
    int t;
    for (int i = 0; i < n; i++) begin
      d[i] = int'($urandom_range(0, maxval));
      s[i] = d[i];
    end
    for (int a = 0; a < n; a++)
      for (int b = 0; b < n - 1 - a; b++)
        if (s[b] < s[b+1]) begin
          t = s[b]; s[b] = s[b+1]; s[b+1] = t;
        end
    for (int i = 0; i < n; i++) begin
      di12   = 12'(d[i]);
      rank_s = (i == 0) ? 5'(r) : 5'd0;
      if (n == 3) dsi3 = 1'b1; else dsi25 = 1'b1;
      tick();
    end
    dsi3  = 1'b0;
    dsi25 = 1'b0;
    await_dso(n, sort_cycles(n, r) + 1, 32'(s[r-1]), $sformatf("n%0d_r%0d", n, r));
  endtask

  initial begin
    logic [7:0] v1 [9];
    logic [7:0] v2 [9];
    logic [7:0] v3 [9];
    v1 = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    v2 = '{8'd7, 8'd7, 8'd7, 8'd2, 8'd2, 8'd200, 8'd200, 8'd7, 8'd0};
    v3 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};

    #1;
    check("rst_rdy", 32'(rdy9), 32'd1);
    check("rst_do", 32'(do9), 32'd0);
    check("rst_dso", 32'(dso9), 32'd0);
    check("rst_drop", 32'(drop9), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    send9(v1, 0, 0);
    await_dso(9, 31, 32'd5, "median");
    send9(v1, 1, 0);
    await_dso(9, 9, 32'd9, "rank1");
    send9(v1, 9, 0);
    await_dso(9, 37, 32'd1, "rank9");
    send9(v1, 12, 0);
    await_dso(9, 31, 32'd5, "rank12");
    send9(v2, 0, 3);
    await_dso(9, 31, 32'd7, "ties_gaps");

    // Strobes during SORT must be dropped and leave the sort untouched
    send9(v1, 0, 0);
    di9  = 8'hAA;
    dsi9 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("drop_pulse%0d", i), 32'(drop9), 32'd1);
    end
    dsi9 = 1'b0;
    tick();
    check("drop_clear", 32'(drop9), 32'd0);
    await_dso(9, 27, 32'd5, "drop_result");
    send9(v2, 0, 0);
    await_dso(9, 31, 32'd7, "after_drop");

    // Abort a frame partway through the sort
    send9(v1, 0, 0);
    for (int i = 0; i < 12; i++) tick();
    nRST = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy9), 32'd1);
    check("midrst_do", 32'(do9), 32'd0);
    check("midrst_dso", 32'(dso9), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    send9(v3, 0, 0);
    await_dso(9, 31, 32'd50, "post_rst");

    for (int r = 1; r <= 3; r++) begin
      frame_small(3, r, 4095);
      frame_small(3, r, 3);
    end
    for (int r = 1; r <= 25; r++) frame_small(25, r, (r % 2 == 0) ? 15 : 4095);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
